// File: rtl/pattern_gen.sv
// pattern_gen -- video test-pattern generator.
// Two-stage free-running pipeline: stage 1 decodes the raster position,
// stage 2 produces the registered red/grn/blu colour.
// Pattern mode changes are taken only at frame start (x==0, y==0).
// Optional feature: define PATTERN_SCROLL_EN to scroll the checker and
// grey-ramp modes horizontally by one pixel per frame.
module pattern_gen #(
  parameter int HWIDTH    = 960,
  parameter int VHEIGHT   = 600,
  parameter int XW        = 11,
  parameter int CW        = 8,
  parameter int CHK_SHIFT = 3
) (
  input  logic            pixclk,
  input  logic            reset,
  input  logic [XW-1:0]   xpixel,
  input  logic [XW-1:0]   ypixel,
  input  logic [2:0]      mode_in,
  input  logic            mode_req,
  input  logic [3*CW-1:0] solid_rgb,
  output logic            mode_ack,
  output logic [2:0]      cur_mode,
  output logic [CW-1:0]   frame_cnt,
  output logic [CW-1:0]   red,
  output logic [CW-1:0]   grn,
  output logic [CW-1:0]   blu
);

  typedef enum logic [2:0] {
    MODE_SOLID   = 3'd0,
    MODE_CHECKER = 3'd1,
    MODE_BARS    = 3'd2,
    MODE_RAMP    = 3'd3,
    MODE_BORDER  = 3'd4,
    MODE_RSVD5   = 3'd5,
    MODE_RSVD6   = 3'd6,
    MODE_RSVD7   = 3'd7
  } mode_e;

  // Bar width in pixels; guarded so tiny widths still give a legal counter.
  localparam int BAR_W = (HWIDTH / 8 > 0) ? HWIDTH / 8 : 1;
  // Number of low x bits the checker and ramp actually need.
  localparam int LW    = (CW > CHK_SHIFT + 1) ? CW : CHK_SHIFT + 1;

  localparam logic [XW-1:0] H_LIM    = XW'(HWIDTH);
  localparam logic [XW-1:0] H_LAST   = XW'(HWIDTH - 1);
  localparam logic [XW-1:0] V_LIM    = XW'(VHEIGHT);
  localparam logic [XW-1:0] V_LAST   = XW'(VHEIGHT - 1);
  localparam logic [XW-1:0] BAR_LAST = XW'(BAR_W - 1);

  // Mode / frame control state
  mode_e         mode_q, mode_d;
  mode_e         pend_mode_q, pend_mode_d;
  logic          pend_valid_q, pend_valid_d;
  logic          mode_ack_q;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic          fs;
  logic          apply;

  // Colour-bar column counter
  logic [XW-1:0] bar_col_q, bar_col_d, col_cur;
  logic [2:0]    bar_idx_q, bar_idx_d, idx_cur;

  // Scrolled low x bits and stage-1 decode
  logic [LW-1:0] xe_lo;
  logic          active;
  logic          border;

  // Stage 1 registers
  logic          s1_active_q;
  mode_e         s1_mode_q;
  logic          s1_chk_r_q;
  logic          s1_chk_g_q;
  logic [CW-1:0] s1_xlo_q;
  logic [CW-1:0] s1_ylo_q;
  logic          s1_border_q;
  logic [2:0]    s1_bar_q;
  logic [3*CW-1:0] s1_solid_q;

  // Stage 2 registers
  logic [CW-1:0] red_q, grn_q, blu_q;
  logic [CW-1:0] red_d, grn_d, blu_d;

  // Frame start detection, pending-request bookkeeping and frame counting.
  // NOTE: every signal written in a combinational block gets a default first so no latch is inferred.
  always_comb begin
    fs           = (xpixel == '0) && (ypixel == '0);
    apply        = fs && (mode_req || pend_valid_q);
    mode_d       = mode_q;
    pend_mode_d  = pend_mode_q;
    pend_valid_d = pend_valid_q;
    frame_cnt_d  = frame_cnt_q;
    if (mode_req) begin
      pend_mode_d  = mode_e'(mode_in);
      pend_valid_d = 1'b1;
    end
    if (apply) begin
      // A same-cycle request beats whatever was pending.
      mode_d       = mode_req ? mode_e'(mode_in) : pend_mode_q;
      pend_valid_d = 1'b0;
    end
    if (fs) begin
      frame_cnt_d = frame_cnt_q + CW'(1);
    end
  end

  // Control registers: active mode, pending request, ack pulse, frame counter.
  // NOTE: sequential state uses non-blocking assignments so every register updates together at the edge.
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      mode_q       <= MODE_SOLID;
      pend_mode_q  <= MODE_SOLID;
      pend_valid_q <= 1'b0;
      mode_ack_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      mode_q       <= mode_d;
      pend_mode_q  <= pend_mode_d;
      pend_valid_q <= pend_valid_d;
      mode_ack_q   <= apply;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Bar index from a per-line column counter; restarts at x==0, saturates at bar 7.
  always_comb begin
    col_cur   = (xpixel == '0) ? '0 : bar_col_q;
    idx_cur   = (xpixel == '0) ? '0 : bar_idx_q;
    bar_col_d = col_cur + XW'(1);
    bar_idx_d = idx_cur;
    if (col_cur == BAR_LAST) begin
      bar_col_d = '0;
      if (idx_cur != 3'd7) begin
        bar_idx_d = idx_cur + 3'd1;
      end
    end
  end

  // Column counter registers.
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      bar_col_q <= '0;
      bar_idx_q <= '0;
    end else begin
      bar_col_q <= bar_col_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  // Effective x for checker/ramp; the frame count used is the one that applies to this pixel's frame.
  always_comb begin
`ifdef PATTERN_SCROLL_EN
    if (mode_d == MODE_CHECKER || mode_d == MODE_RAMP) begin
      xe_lo = xpixel[LW-1:0] + LW'(frame_cnt_d);
    end else begin
      xe_lo = xpixel[LW-1:0];
    end
`else
    xe_lo = xpixel[LW-1:0];
`endif
  end

  // Active-area and border decode of the current raster position.
  always_comb begin
    active = (xpixel < H_LIM) && (ypixel < V_LIM);
    border = (xpixel == '0) || (xpixel == H_LAST) ||
             (ypixel == '0) || (ypixel == V_LAST);
  end

  // Stage 1: capture the decoded position together with the mode this frame uses.
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      s1_active_q <= 1'b0;
      s1_mode_q   <= MODE_SOLID;
      s1_chk_r_q  <= 1'b0;
      s1_chk_g_q  <= 1'b0;
      s1_xlo_q    <= '0;
      s1_ylo_q    <= '0;
      s1_border_q <= 1'b0;
      s1_bar_q    <= '0;
      s1_solid_q  <= '0;
    end else begin
      s1_active_q <= active;
      s1_mode_q   <= mode_d;
      s1_chk_r_q  <= xe_lo[CHK_SHIFT];
      s1_chk_g_q  <= ypixel[CHK_SHIFT];
      s1_xlo_q    <= xe_lo[CW-1:0];
      s1_ylo_q    <= ypixel[CW-1:0];
      s1_border_q <= border;
      s1_bar_q    <= idx_cur;
      s1_solid_q  <= solid_rgb;
    end
  end

  // Stage 2 colour selection; outside the active area every mode is black.
  always_comb begin
    red_d = '0;
    grn_d = '0;
    blu_d = '0;
    if (s1_active_q) begin
      case (s1_mode_q)
        MODE_SOLID: begin
          {red_d, grn_d, blu_d} = s1_solid_q;
        end
        MODE_CHECKER: begin
          red_d = {CW{s1_chk_r_q}};
          grn_d = {CW{s1_chk_g_q}};
          blu_d = s1_ylo_q;
        end
        MODE_BARS: begin
          // White, yellow, cyan, green, magenta, red, blue, black.
          red_d = {CW{~s1_bar_q[1]}};
          grn_d = {CW{~s1_bar_q[2]}};
          blu_d = {CW{~s1_bar_q[0]}};
        end
        MODE_RAMP: begin
          red_d = s1_xlo_q;
          grn_d = s1_xlo_q;
          blu_d = s1_xlo_q;
        end
        MODE_BORDER: begin
          red_d = {CW{s1_border_q}};
          grn_d = {CW{s1_border_q}};
          blu_d = {CW{s1_border_q}};
        end
        default: begin
          red_d = '0;
          grn_d = '0;
          blu_d = '0;
        end
      endcase
    end
  end

  // Stage 2 output registers.
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      red_q <= '0;
      grn_q <= '0;
      blu_q <= '0;
    end else begin
      red_q <= red_d;
      grn_q <= grn_d;
      blu_q <= blu_d;
    end
  end

  assign mode_ack  = mode_ack_q;
  assign cur_mode  = mode_q;
  assign frame_cnt = frame_cnt_q;
  assign red       = red_q;
  assign grn       = grn_q;
  assign blu       = blu_q;

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen -- self-checking bench for pattern_gen (default parameters).
module tb_pattern_gen;

  localparam int HWIDTH  = 960;
  localparam int VHEIGHT = 600;
  localparam int XW      = 11;
  localparam int CW      = 8;
`ifdef PATTERN_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic          pixclk = 1'b0;
  logic          reset;
  logic [XW-1:0] xpixel;
  logic [XW-1:0] ypixel;
  logic [2:0]    mode_in;
  logic          mode_req;
  logic [23:0]   solid_rgb;
  logic          mode_ack;
  logic [2:0]    cur_mode;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] red, grn, blu;

  pattern_gen #(
    .HWIDTH(HWIDTH), .VHEIGHT(VHEIGHT), .XW(XW), .CW(CW), .CHK_SHIFT(3)
  ) dut (
    .pixclk(pixclk), .reset(reset), .xpixel(xpixel), .ypixel(ypixel),
    .mode_in(mode_in), .mode_req(mode_req), .solid_rgb(solid_rgb),
    .mode_ack(mode_ack), .cur_mode(cur_mode), .frame_cnt(frame_cnt),
    .red(red), .grn(grn), .blu(blu)
  );

  always #5 pixclk = ~pixclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          m_mode, m_pend, m_fc;
  bit          m_pvalid, m_ack;
  logic [23:0] prev_pix;

  typedef struct {
    int          x;
    int          y;
    int          mode;
    logic [23:0] solid;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] ref_pixel(input int mode, input int x, input int y,
                                            input int fc, input logic [23:0] solid);
    int xe;
    int bar;
    logic [7:0] v;
    if (x >= HWIDTH || y >= VHEIGHT) return 24'h0;
    xe = x;
    if (SCROLL && (mode == 1 || mode == 3)) xe = (x + fc) % 2048;
    case (mode)
      0: return solid;
      1: begin
        v = 8'(y % 256);
        return {(((xe >> 3) & 1) != 0) ? 8'hFF : 8'h00,
                (((y >> 3) & 1) != 0) ? 8'hFF : 8'h00, v};
      end
      2: begin
        bar = x / (HWIDTH / 8);
        if (bar > 7) bar = 7;
        return BARS[bar];
      end
      3: begin
        v = 8'(xe % 256);
        return {v, v, v};
      end
      4: return (x == 0 || x == HWIDTH - 1 || y == 0 || y == VHEIGHT - 1) ? 24'hFFFFFF : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  function automatic void model_reset();
    m_mode   = 0;
    m_pend   = 0;
    m_pvalid = 1'b0;
    m_fc     = 0;
    m_ack    = 1'b0;
    prev_pix = 24'h0;
  endfunction

  // One pixel clock: drive a sample at the falling edge, advance the model,
  // then check every output half a period after the rising edge.
  task automatic cycle(input int x, input int y, input int mode, input bit req,
                       input logic [23:0] solid);
    logic [23:0] pix;
    bit          fs;
    xpixel    = XW'(x);
    ypixel    = XW'(y);
    mode_in   = 3'(mode);
    mode_req  = req;
    solid_rgb = solid;
    fs    = (x == 0) && (y == 0);
    m_ack = 1'b0;
    if (fs) begin
      m_fc = (m_fc + 1) % 256;
      if (req || m_pvalid) begin
        m_mode   = req ? mode : m_pend;
        m_pvalid = 1'b0;
        m_ack    = 1'b1;
      end
    end
    if (req && !fs) begin
      m_pend   = mode;
      m_pvalid = 1'b1;
    end
    pix = ref_pixel(m_mode, x, y, m_fc, solid);
    @(posedge pixclk);
    @(negedge pixclk);
    check("cur_mode", {29'd0, cur_mode}, m_mode);
    check("frame_cnt", {24'd0, frame_cnt}, m_fc);
    check("mode_ack", {31'd0, mode_ack}, {31'd0, m_ack});
    check("rgb", {8'd0, red, grn, blu}, {8'd0, prev_pix});
    prev_pix = pix;
  endtask

  task automatic set_mode(input int mode, input logic [23:0] solid);
    cycle(0, 0, mode, 1'b1, solid);
  endtask

  // Assert reset mid-frame with a request on mode_req, check outputs before any edge.
  task automatic reset_midframe();
    reset    = 1'b1;
    mode_req = 1'b1;
    mode_in  = 3'd6;
    #1;
    check("rst_rgb", {8'd0, red, grn, blu}, 32'h0);
    check("rst_cur_mode", {29'd0, cur_mode}, 32'h0);
    check("rst_frame_cnt", {24'd0, frame_cnt}, 32'h0);
    check("rst_mode_ack", {31'd0, mode_ack}, 32'h0);
    @(posedge pixclk);
    @(negedge pixclk);
    check("rst_hold_cur_mode", {29'd0, cur_mode}, 32'h0);
    reset    = 1'b0;
    mode_req = 1'b0;
    model_reset();
  endtask

  function automatic void add_vec(input int x, input int y, input int mode,
                                  input logic [23:0] solid, input logic [23:0] exp);
    vec_t v;
    v.x = x; v.y = y; v.mode = mode; v.solid = solid; v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [23:0] exp_bar;
    int          ry;
    int          rlen;
    logic [23:0] rsolid;
    bit          rreq;

    // Power-on reset
    reset = 1'b1; xpixel = '0; ypixel = '0; mode_in = '0; mode_req = 1'b0; solid_rgb = '0;
    model_reset();
    #1;
    check("por_rgb", {8'd0, red, grn, blu}, 32'h0);
    check("por_cur_mode", {29'd0, cur_mode}, 32'h0);
    check("por_frame_cnt", {24'd0, frame_cnt}, 32'h0);
    @(negedge pixclk);
    reset = 1'b0;

    // Directed vectors: solid/blanking, checker, ramp, border, reserved modes
    add_vec(959, 599, 0, 24'h123456, 24'h123456);
    add_vec(960, 599, 0, 24'h123456, 24'h000000);
    add_vec(959, 600, 0, 24'h123456, 24'h000000);
    add_vec(0,   5,   0, 24'h123456, 24'h123456);
    add_vec(2047, 2047, 0, 24'h123456, 24'h000000);
    add_vec(300, 300, 0, 24'hA5C3E1, 24'hA5C3E1);
`ifndef PATTERN_SCROLL_EN
    add_vec(8,   1,   1, 24'h123456, 24'hFF0001);
    add_vec(7,   8,   1, 24'h123456, 24'h00FF08);
    add_vec(15,  13,  1, 24'h123456, 24'hFFFF0D);
    add_vec(100, 599, 1, 24'h123456, 24'h000057);
    add_vec(960, 5,   1, 24'h123456, 24'h000000);
    add_vec(10,  3,   3, 24'h123456, 24'h0A0A0A);
    add_vec(300, 3,   3, 24'h123456, 24'h2C2C2C);
    add_vec(959, 598, 3, 24'h123456, 24'hBFBFBF);
    add_vec(960, 3,   3, 24'h123456, 24'h000000);
`endif
    add_vec(0,   300, 4, 24'h123456, 24'hFFFFFF);
    add_vec(959, 10,  4, 24'h123456, 24'hFFFFFF);
    add_vec(500, 0,   4, 24'h123456, 24'hFFFFFF);
    add_vec(500, 599, 4, 24'h123456, 24'hFFFFFF);
    add_vec(500, 300, 4, 24'h123456, 24'h000000);
    add_vec(960, 0,   4, 24'h123456, 24'h000000);
    add_vec(1,   1,   4, 24'h123456, 24'h000000);
    add_vec(10,  10,  5, 24'h123456, 24'h000000);
    add_vec(10,  10,  7, 24'h123456, 24'h000000);

    foreach (vecs[i]) begin
      if (m_mode != vecs[i].mode) set_mode(vecs[i].mode, vecs[i].solid);
      cycle(vecs[i].x, vecs[i].y, vecs[i].mode, 1'b0, vecs[i].solid);
      cycle(vecs[i].x, vecs[i].y, vecs[i].mode, 1'b0, vecs[i].solid);
      check($sformatf("vec%0d_rgb", i), {8'd0, red, grn, blu}, {8'd0, vecs[i].exp});
    end

    // Mode change requested mid-frame waits for the next frame start
    set_mode(0, 24'h123456);
    cycle(100, 50, 2, 1'b1, 24'h123456);
    check("midframe_cur_mode", {29'd0, cur_mode}, 32'd0);
    for (int x = 101; x < 105; x++) cycle(x, 50, 0, 1'b0, 24'h123456);
    check("pending_cur_mode", {29'd0, cur_mode}, 32'd0);
    check("pending_no_ack", {31'd0, mode_ack}, 32'd0);
    cycle(0, 0, 0, 1'b0, 24'h123456);
    check("fs_cur_mode", {29'd0, cur_mode}, 32'd2);
    check("fs_ack", {31'd0, mode_ack}, 32'd1);
    cycle(1, 0, 0, 1'b0, 24'h123456);
    check("ack_single", {31'd0, mode_ack}, 32'd0);

    // Colour bars across a full line
    for (int x = 0; x <= HWIDTH; x++) begin
      cycle(x, 1, 0, 1'b0, 24'h123456);
      if (x == 1 || x == 120 || x == 121 || x == 960) begin
        case (x - 1)
          0:       exp_bar = 24'hFFFFFF;
          119:     exp_bar = 24'hFFFFFF;
          120:     exp_bar = 24'hFFFF00;
          default: exp_bar = 24'h000000;
        endcase
        check($sformatf("bar_x%0d", x - 1), {8'd0, red, grn, blu}, {8'd0, exp_bar});
      end
    end

    // Overwrite of a pending request, then same-cycle precedence at frame start
    cycle(0, 20, 0, 1'b0, 24'h123456);
    cycle(1, 20, 1, 1'b1, 24'h123456);
    cycle(2, 20, 4, 1'b1, 24'h123456);
    cycle(3, 20, 0, 1'b0, 24'h123456);
    check("overwrite_hold", {29'd0, cur_mode}, 32'd2);
    cycle(0, 0, 0, 1'b0, 24'h123456);
    check("overwrite_mode", {29'd0, cur_mode}, 32'd4);
    check("overwrite_ack", {31'd0, mode_ack}, 32'd1);
    cycle(1, 0, 0, 1'b0, 24'h123456);
    check("overwrite_ack_once", {31'd0, mode_ack}, 32'd0);
    cycle(2, 0, 5, 1'b1, 24'h123456);
    cycle(0, 0, 3, 1'b1, 24'h123456);
    check("samecycle_mode", {29'd0, cur_mode}, 32'd3);
    check("samecycle_ack", {31'd0, mode_ack}, 32'd1);

    // Reset mid-frame discards the pending request and ignores mode_req under reset
    cycle(4, 7, 0, 1'b0, 24'h123456);
    cycle(5, 7, 5, 1'b1, 24'h123456);
    reset_midframe();
    cycle(0, 0, 0, 1'b0, 24'h123456);
    check("post_rst_mode", {29'd0, cur_mode}, 32'd0);
    check("post_rst_ack", {31'd0, mode_ack}, 32'd0);

    // Grey ramp at frame count 5, x=10
    set_mode(3, 24'h123456);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1'b0, 24'h123456);
    check("scroll_fcnt", {24'd0, frame_cnt}, 32'd5);
    cycle(10, 1, 0, 1'b0, 24'h123456);
    cycle(11, 1, 0, 1'b0, 24'h123456);
    check("scroll_ramp", {8'd0, red, grn, blu}, SCROLL ? 32'h0F0F0F : 32'h0A0A0A);

    // Randomised raster lines against the reference model
    for (int ln = 0; ln < 40; ln++) begin
      ry     = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, VHEIGHT + 3));
      rlen   = ($urandom_range(0, 3) == 0) ? HWIDTH + 4 : int'($urandom_range(1, 300));
      rsolid = 24'($urandom);
      for (int x = 0; x < rlen; x++) begin
        rreq = ($urandom_range(0, 49) == 0);
        cycle(x, ry, int'($urandom_range(0, 7)), rreq, rsolid);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 SHALL have parameter HWIDTH, default 960, meaning the active pixels per line.
REQ-002 SHALL have parameter VHEIGHT, default 600, meaning the active lines per frame.
REQ-003 SHALL have parameter XW, default 11, meaning the width of the pixel coordinates.
REQ-004 SHALL have parameter CW, default 8, meaning the bits per colour channel.
REQ-005 SHALL have parameter CHK_SHIFT, default 3, meaning the coordinate bit that selects a checker cell.
REQ-006 SHALL have port pixclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous reset, active-high.
REQ-008 SHALL have port xpixel, input, XW bits: the current column from the timing core.
REQ-009 SHALL have port ypixel, input, XW bits: the current line from the timing core.
REQ-010 SHALL have port mode_in, input, 3 bits: the requested pattern mode.
REQ-011 SHALL have port mode_req, input, 1 bit: a one-cycle strobe requesting mode_in.
REQ-012 SHALL have port solid_rgb, input, 3*CW bits: the solid colour as {red,grn,blu}.
REQ-013 SHALL have port mode_ack, output, 1 bit: a one-cycle pulse when the pending mode is applied.
REQ-014 SHALL have port cur_mode, output, 3 bits: the active mode.
REQ-015 SHALL have port frame_cnt, output, CW bits: the frame counter.
REQ-016 SHALL have ports red, grn and blu, outputs, CW bits each: the registered pixel colour.

Function
REQ-017 SHALL treat a cycle with xpixel==0 and ypixel==0 as frame start (FS).
REQ-018 SHALL latch mode_in into a pending register on mode_req and set pending_valid.
- A later mode_req SHALL overwrite the pending value.
REQ-019 SHALL, on FS with pending_valid set (or mode_req in the same cycle, which takes precedence):
- load cur_mode;
- clear pending_valid;
- pulse mode_ack in the next cycle.
- A mode change SHALL never occur mid-frame.
REQ-020 SHALL increment frame_cnt on every FS, wrapping modulo 2^CW.
REQ-021 SHALL register red/grn/blu exactly 2 cycles after the xpixel/ypixel sample they correspond to (stage 1 decode, stage 2 colour); the pipeline SHALL be free-running with no stalls.
REQ-022 SHALL output all-zero channels where xpixel>=HWIDTH or ypixel>=VHEIGHT, regardless of mode.
REQ-023 SHALL implement mode 0, solid: outputs equal solid_rgb.
REQ-024 SHALL implement mode 1, checker:
- red = all-ones iff xe[CHK_SHIFT];
- grn = all-ones iff ypixel[CHK_SHIFT];
- blu = ypixel[CW-1:0].
REQ-025 SHALL implement mode 2, colour bars: eight bars, ordered white, yellow, cyan, green, magenta, red, blue, black.
- Bars SHALL be HWIDTH/8 pixels wide, with integer division.
- The bar index SHALL come from a column counter cleared at xpixel==0, with no divider.
- The index SHALL saturate at 7, so remainder columns are black.
REQ-026 SHALL implement mode 3, grey ramp: all channels = xe[CW-1:0], wrapping.
REQ-027 SHALL implement mode 4, border: all-ones on x==0, x==HWIDTH-1, y==0 and y==VHEIGHT-1; zero elsewhere.
REQ-028 SHALL output zero in modes 5-7.
REQ-029 SHALL define xe as xpixel, or as the scrolled coordinate per REQ-034.
REQ-030 SHALL compute coordinate arithmetic modulo 2^XW with no saturation.

Reset
REQ-031 SHALL, while reset is asserted, asynchronously force:
- red/grn/blu = 0;
- cur_mode = 0;
- pending_valid = 0;
- mode_ack = 0;
- frame_cnt = 0;
- all pipeline stages = 0.
REQ-032 SHALL discard any pending request when reset is asserted mid-frame; after release, outputs SHALL be valid from the 2nd clock.
REQ-033 SHALL NOT honour mode_req asserted while reset is high.

Configuration
REQ-034 SHALL, with macro PATTERN_SCROLL_EN defined, set xe = xpixel + frame_cnt (zero-extended, modulo 2^XW) for modes 1 and 3 only; this scrolls the pattern one pixel per frame.
REQ-035 SHALL, without PATTERN_SCROLL_EN, set xe = xpixel; frame_cnt SHALL still count and be output.

Verification
REQ-036 SHALL cover reset defaults: reset high mid-frame -> all outputs 0, cur_mode=0, frame_cnt=0 immediately, without a clock edge.
REQ-037 SHALL cover frame-boundary mode change: mode_req with mode_in=2 at x=100,y=50 -> cur_mode stays 0 until the next FS; mode_ack pulses once, 1 cycle after FS.
REQ-038 SHALL cover colour bars, mode 2 with HWIDTH=960: x=0 -> FFFFFF; x=119 -> FFFFFF; x=120 -> FFFF00; x=959 -> 000000; outputs appear at 2-cycle latency.
REQ-039 SHALL cover overwrite and same-cycle precedence:
- mode_req 1, then mode_req 4 before FS -> cur_mode=4, with one mode_ack;
- mode_req 3 on the FS cycle -> applied at that FS.
REQ-040 SHALL cover blanking: mode 0 with solid_rgb=123456 -> 123456 at x=959,y=599; 000000 at x=960 or y=600.
REQ-041 SHALL cover scroll with PATTERN_SCROLL_EN defined: mode 3, frame_cnt=5, x=10 -> all channels 0x0F; without the macro -> 0x0A.
